pm_rate_meter: RTL



---
 rtl/pm_pkg.sv | 39 +++
 rtl/pm_gap_tracker.sv | 81 ++++++++
 rtl/pm_rate_meter.sv | 103 ++++++++++
 3 files changed

// File: rtl/pm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pm_pkg
//  Description : Shared helpers for the rate meter: saturating increment,
//                counter-width calculation and the expected inter-frame gap
//                of a pacer configured with SIZE/FREQUENCY/BANDWIDTH.
//  Revision    : 1.0 - initial release
// ============================================================================
package pm_pkg;

    // Increment value by one, saturating at the all-ones value of a
    // width-bit field. Callers cast the result back to their own width.
    function automatic logic [63:0] sat_inc(input logic [63:0] value, input int width);
        logic [63:0] max_val;
        max_val = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
        return (value >= max_val) ? max_val : value + 64'd1;
    endfunction

    // Bits needed to hold 0..n-1 (minimum 1).
    function automatic int unsigned cnt_width(input longint unsigned n);
        int unsigned w;
        w = 1;
        for (int i = 1; i < 64; i++) begin
            if ((64'd1 << w) < n) w = w + 1;
        end
        return w;
    endfunction

    // Whole clk cycles per frame for SIZE bytes at BANDWIDTH kbit/s with
    // clk at FREQUENCY kHz. The fractional part is dropped, so a pacer with
    // a fractional period shows gaps of this value and this value + 1.
    function automatic int unsigned EXPECTED_GAP(input longint unsigned SIZE,
                                                 input longint unsigned FREQUENCY,
                                                 input longint unsigned BANDWIDTH);
        return 32'((SIZE * 64'd8 * FREQUENCY) / BANDWIDTH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pm_gap_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : pm_gap_tracker
//  Description : Inter-pulse gap tracker. Counts cycles since the last pulse
//                and keeps per-window min/max gap accumulators.
//  Ports       : clk, rst         - clock, async active-high reset
//                i_clear          - hold everything at reset values
//                i_pulse          - qualified frame-start pulse
//                i_win_close      - window boundary: restart min/max
//                o_min_next/o_max_next - accumulators including this cycle's gap
//  Revision    : 1.0 - initial release
// ============================================================================
module pm_gap_tracker
    import pm_pkg::*;
#(
    parameter int GAP_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_pulse,
    input  logic                 i_win_close,
    output logic [GAP_WIDTH-1:0] o_min_next,
    output logic [GAP_WIDTH-1:0] o_max_next
);

    localparam logic [GAP_WIDTH-1:0] c_ALL_ONES = '1;

    logic [GAP_WIDTH-1:0] r_gcnt;
    logic                 r_have_prev;
    logic [GAP_WIDTH-1:0] r_min;
    logic [GAP_WIDTH-1:0] r_max;

    // gcnt+1 saturating: both the next gap counter value and the gap
    // length if a pulse lands this cycle.
    logic [GAP_WIDTH-1:0] w_gcnt_inc;
    logic                 w_gap_hit;

    assign w_gcnt_inc = GAP_WIDTH'(sat_inc(64'(r_gcnt), GAP_WIDTH));
    assign w_gap_hit  = i_pulse & r_have_prev;

    always_comb begin
        o_min_next = r_min;
        o_max_next = r_max;
        if (w_gap_hit) begin
            if (w_gcnt_inc < r_min) o_min_next = w_gcnt_inc;
            if (w_gcnt_inc > r_max) o_max_next = w_gcnt_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gcnt      <= '0;
            r_have_prev <= 1'b0;
            r_min       <= c_ALL_ONES;
            r_max       <= '0;
        end else if (i_clear) begin
            r_gcnt      <= '0;
            r_have_prev <= 1'b0;
            r_min       <= c_ALL_ONES;
            r_max       <= '0;
        end else begin
            if (i_pulse) begin
                r_gcnt      <= '0;
                r_have_prev <= 1'b1;
            end else begin
                r_gcnt <= w_gcnt_inc;
            end
            // Gap tracking spans windows; only the extremes restart.
            if (i_win_close) begin
                r_min <= c_ALL_ONES;
                r_max <= '0;
            end else begin
                r_min <= o_min_next;
                r_max <= o_max_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pm_rate_meter.sv
`default_nettype none
// ============================================================================
//  Module      : pm_rate_meter
//  Description : Frame-rate meter. Counts frame-start pulses and min/max
//                inter-pulse gap over a fixed window of clk cycles and
//                presents each window's result on a valid/ready stats port.
//  Ports       : clk, rst        - clock, async active-high reset
//                enable          - measure when high; low clears accumulators
//                pulse_in        - one-cycle frame-start pulse
//                stat_count/stat_min_gap/stat_max_gap/stat_overrun - snapshot
//                stat_valid/stat_ready - snapshot handshake
//  Revision    : 1.0 - initial release
// ============================================================================
module pm_rate_meter
    import pm_pkg::*;
#(
    parameter int WINDOW_CYCLES = 350000,
    parameter int COUNT_WIDTH   = 32,
    parameter int GAP_WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   pulse_in,
    output logic [COUNT_WIDTH-1:0] stat_count,
    output logic [GAP_WIDTH-1:0]   stat_min_gap,
    output logic [GAP_WIDTH-1:0]   stat_max_gap,
    output logic                   stat_overrun,
    output logic                   stat_valid,
    input  logic                   stat_ready
);

    localparam int unsigned             c_WCNT_W    = cnt_width(64'(WINDOW_CYCLES));
    localparam logic [c_WCNT_W-1:0]     c_WCNT_LAST = c_WCNT_W'(WINDOW_CYCLES - 1);

    logic [c_WCNT_W-1:0]    r_wcnt;
    logic [COUNT_WIDTH-1:0] r_count;

    logic                   w_pulse;
    logic                   w_boundary;
    logic                   w_xfer;
    logic [COUNT_WIDTH-1:0] w_count_next;
    logic [GAP_WIDTH-1:0]   w_min_next;
    logic [GAP_WIDTH-1:0]   w_max_next;

    assign w_pulse      = enable & pulse_in;
    assign w_boundary   = enable & (r_wcnt == c_WCNT_LAST);
    assign w_xfer       = stat_valid & stat_ready;
    assign w_count_next = w_pulse ? COUNT_WIDTH'(sat_inc(64'(r_count), COUNT_WIDTH)) : r_count;

    pm_gap_tracker #(
        .GAP_WIDTH (GAP_WIDTH)
    ) u_gap_tracker (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (~enable),
        .i_pulse     (w_pulse),
        .i_win_close (w_boundary),
        .o_min_next  (w_min_next),
        .o_max_next  (w_max_next)
    );

    // Window position and pulse count; both held at zero while disabled so
    // that enable rising starts a fresh, full-length window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wcnt  <= '0;
            r_count <= '0;
        end else if (!enable) begin
            r_wcnt  <= '0;
            r_count <= '0;
        end else if (w_boundary) begin
            r_wcnt  <= '0;
            r_count <= '0;
        end else begin
            r_wcnt  <= r_wcnt + c_WCNT_W'(1);
            r_count <= w_count_next;
        end
    end

    // Snapshot register and handshake. Runs regardless of enable so a
    // pending result stays collectable while measurement is paused.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_count   <= '0;
            stat_min_gap <= '0;
            stat_max_gap <= '0;
            stat_overrun <= 1'b0;
            stat_valid   <= 1'b0;
        end else if (w_boundary) begin
            stat_count   <= w_count_next;
            stat_min_gap <= w_min_next;
            stat_max_gap <= w_max_next;
            // Only an unread snapshot that is not leaving this edge is lost.
            stat_overrun <= stat_valid & ~stat_ready;
            stat_valid   <= 1'b1;
        end else if (w_xfer) begin
            stat_valid   <= 1'b0;
        end
    end

endmodule
`default_nettype wire
